ps2_host_transmitter: RTL and testbench
=======================================

Name: ps2_host_transmitter

Overview:
Host-to-device PS/2 transmitter. It sends one command byte (e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable) from the synthesizer to the keyboard over the same two-wire open-drain clock/data bus that the keyboard scan-code receiver listens on. The transmitter performs the request-to-send sequence, shifts out the frame on device-generated clock edges and checks the device's acknowledge bit. While the transmitter is busy, the receiver path must ignore the bus.

Parameters:
INHIBIT_CYCLES, 5000, system clocks the bus clock is held low before request-to-send (100 us at 50 MHz).
TIMEOUT_CYCLES, 750000, maximum system clocks between successive device clock falling edges, or from release to the first edge (15 ms at 50 MHz).

Ports:
clock  in  1  system clock; all logic on its rising edge.
reset  in  1  asynchronous, active-high reset.
cmd_data  in  8  byte to send; sampled when cmd_valid && cmd_ready.
cmd_valid  in  1  request to send cmd_data.
cmd_ready  out  1  high only in IDLE.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse when a transfer ends, successful or not.
ack_error  out  1  valid with done: 1 = NACK or timeout, 0 = acknowledged.
ps2_clk_in  in  1  bus clock pin level.
ps2_data_in  in  1  bus data pin level.
ps2_clk_drive_low  out  1  1 = pull bus clock low, 0 = release it (tristate handled at top level).
ps2_data_drive_low  out  1  1 = pull bus data low, 0 = release it.

Behaviour:
- Reset value of every output:
  - cmd_ready=1; all other outputs 0 (both lines released).
  - State = IDLE; all counters cleared.
- Reset asserted mid-transfer: both lines are released immediately and done is NOT pulsed.
- Input synchronisation:
  - ps2_clk_in and ps2_data_in each pass through 2-flop synchronisers.
  - A falling edge is registered-previous=1 and synced-current=0.
  - All protocol decisions use the synced signals only.
- Frame: start(0), data bits LSB first, odd parity (parity = ~^cmd_data), stop(1), device ACK.
- States:
  - IDLE: cmd_ready=1. On cmd_valid, latch shift register {stop=1, parity, cmd_data}, clear counters -> INHIBIT.
  - INHIBIT: clk_drive_low=1 for INHIBIT_CYCLES cycles. On the last cycle also assert data_drive_low=1 -> RTS.
  - RTS: one cycle with clk_drive_low=1 and data_drive_low=1. Then release the clock (data stays low; this is the start bit) -> SEND. Timeout counter cleared.
  - SEND: on each device clock falling edge, drive the next frame bit. Drive data low for a 0, release it for a 1.
    - Edges 1-8: data bits 0..7.
    - Edge 9: parity.
    - Edge 10: stop (released).
    - After edge 10 -> ACK.
  - ACK: on the next falling edge (edge 11), sample synced data. 0 = ACK, 1 = NACK -> WAIT_IDLE.
  - WAIT_IDLE: wait until synced clock and synced data are both 1. Then pulse done with ack_error = NACK flag -> IDLE.
- Bit counter: 4 bits, counts 0..11, no wrap-around.
- Timeout counter:
  - Runs in SEND, ACK and WAIT_IDLE; cleared on every device falling edge.
  - Reaching TIMEOUT_CYCLES: release both lines, pulse done with ack_error=1 -> IDLE.
- Timeout at the same time as an edge: the edge wins and the counter clears.
- cmd_valid outside IDLE is ignored; there is no queuing.
- cmd_data may change freely after acceptance.
- Device clock edges seen in IDLE or INHIBIT are ignored.
- Back-to-back commands: a new cmd_valid is accepted no earlier than the cycle after done.
- ps2_clk_drive_low is never asserted outside INHIBIT/RTS.

Test Plan:
- Params INHIBIT_CYCLES=8, TIMEOUT_CYCLES=200; send 0xED; device model clocks 11 edges and drives ACK=0 -> required response:
  - clk held low exactly 8 cycles, then start bit;
  - data sampled on rising edges = 0,1,0,1,1,0,1,1,1, parity 1, stop 1;
  - done=1 with ack_error=0.
- Send 0xF4 -> parity bit 0 on edge 9; ACK -> ack_error=0.
- Send 0xFF -> parity 1; device leaves data high at edge 11 -> done with ack_error=1.
- Device stops clocking after edge 4 -> done with ack_error=1 exactly 200 cycles after edge 4; both drive outputs 0.
- Assert reset during SEND bit 5 -> drives 0 immediately, cmd_ready=1, no done pulse; a following 0xF4 completes normally.
- Pulse cmd_valid while busy with 0x00 -> ignored; frame of the original 0xED is unchanged; only one done.

Source files
------------

// File: rtl/ps2_host_transmitter.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, frame shift-out on
// device clock falling edges, ACK check, with a per-edge watchdog.
module ps2_host_transmitter #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] cmd_data,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  output logic       busy,
  output logic       done,
  output logic       ack_error,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_drive_low,
  output logic       ps2_data_drive_low,
  output logic [2:0] dbg_state
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INHIBIT   = 3'd1,
    S_RTS       = 3'd2,
    S_SEND      = 3'd3,
    S_ACK       = 3'd4,
    S_WAIT_IDLE = 3'd5
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic r_clk_meta, r_clk_sync, r_clk_prev;
  logic r_data_meta, r_data_sync;

  logic [9:0]       r_shift;
  logic [3:0]       r_bit_cnt;
  logic             r_data_low;
  logic             r_nack;
  logic [INH_W-1:0] r_inh_cnt;
  logic [TO_W-1:0]  r_to_cnt;

  logic w_clk_fall;
  logic w_inh_last;
  logic w_timing;
  logic w_timeout;
  logic w_bus_idle;

  // Synchronisers reset to the idle bus level so reset release never looks like an edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_clk_meta  <= 1'b1;
      r_clk_sync  <= 1'b1;
      r_clk_prev  <= 1'b1;
      r_data_meta <= 1'b1;
      r_data_sync <= 1'b1;
    end else begin
      r_clk_meta  <= ps2_clk_in;
      r_clk_sync  <= r_clk_meta;
      r_clk_prev  <= r_clk_sync;
      r_data_meta <= ps2_data_in;
      r_data_sync <= r_data_meta;
    end
  end

  assign w_clk_fall = r_clk_prev & ~r_clk_sync;
  assign w_inh_last = (r_inh_cnt == INH_LAST);
  assign w_timing   = (r_state == S_SEND) || (r_state == S_ACK) || (r_state == S_WAIT_IDLE);
  // A device edge in the same cycle as expiry restarts the watchdog instead.
  assign w_timeout  = w_timing && !w_clk_fall && (r_to_cnt == TO_LAST);
  assign w_bus_idle = r_clk_sync & r_data_sync;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:      if (cmd_valid) w_next_state = S_INHIBIT;
      S_INHIBIT:   if (w_inh_last) w_next_state = S_RTS;
      S_RTS:       w_next_state = S_SEND;
      S_SEND: begin
        if (w_timeout)                             w_next_state = S_IDLE;
        else if (w_clk_fall && r_bit_cnt == 4'd9)  w_next_state = S_ACK;
      end
      S_ACK: begin
        if (w_timeout)       w_next_state = S_IDLE;
        else if (w_clk_fall) w_next_state = S_WAIT_IDLE;
      end
      S_WAIT_IDLE: if (w_timeout || w_bus_idle) w_next_state = S_IDLE;
      default:     w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_data_low <= 1'b0;
      r_nack     <= 1'b0;
      r_inh_cnt  <= '0;
      r_to_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_bit_cnt  <= '0;
          r_data_low <= 1'b0;
          r_nack     <= 1'b0;
          r_inh_cnt  <= '0;
          r_to_cnt   <= '0;
          if (cmd_valid) r_shift <= {1'b1, ~^cmd_data, cmd_data};
        end
        S_INHIBIT: if (!w_inh_last) r_inh_cnt <= r_inh_cnt + INH_W'(1);
        S_RTS: begin
          r_data_low <= 1'b1;
          r_to_cnt   <= '0;
        end
        S_SEND: begin
          if (w_clk_fall) begin
            r_data_low <= ~r_shift[0];
            r_shift    <= {1'b0, r_shift[9:1]};
            r_bit_cnt  <= r_bit_cnt + 4'd1;
            r_to_cnt   <= '0;
          end else if (!w_timeout) begin
            r_to_cnt   <= r_to_cnt + TO_W'(1);
          end
        end
        S_ACK: begin
          if (w_clk_fall) begin
            r_nack    <= r_data_sync;
            r_bit_cnt <= r_bit_cnt + 4'd1;
            r_to_cnt  <= '0;
          end else if (!w_timeout) begin
            r_to_cnt  <= r_to_cnt + TO_W'(1);
          end
        end
        S_WAIT_IDLE: if (!w_timeout) r_to_cnt <= r_to_cnt + TO_W'(1);
        default: ;
      endcase
    end
  end

  // Command handshake: cmd_data is taken on the cycle where cmd_valid && cmd_ready; no queuing.
  always_comb begin
    cmd_ready          = (r_state == S_IDLE);
    busy               = (r_state != S_IDLE);
    ps2_clk_drive_low  = (r_state == S_INHIBIT) || (r_state == S_RTS);
    ps2_data_drive_low = ((r_state == S_INHIBIT) && w_inh_last) || (r_state == S_RTS) ||
                         ((r_state == S_SEND) && r_data_low && !w_timeout);
    done               = w_timeout || ((r_state == S_WAIT_IDLE) && w_bus_idle);
    ack_error          = w_timeout || ((r_state == S_WAIT_IDLE) && w_bus_idle && r_nack);
    dbg_state          = r_state;
  end

endmodule

// File: tb/tb_ps2_host_transmitter.sv
// Directed bench for ps2_host_transmitter: an open-drain device model clocks frames,
// and a table of commands plus hand sequences cover NACK, timeout, reset and busy cases.
module tb_ps2_host_transmitter;

  localparam int INH  = 8;
  localparam int TOUT = 200;
  localparam int HALF = 12;
  localparam int SYNC_DELAY = 2;

  typedef struct {
    logic [7:0] cmd;
    logic       dev_ack;
    logic       exp_parity;
    logic       exp_err;
  } vec_t;

  logic       clock;
  logic       reset;
  logic [7:0] cmd_data;
  logic       cmd_valid;
  logic       cmd_ready, busy, done, ack_error;
  logic       ps2_clk_in, ps2_data_in;
  logic       ps2_clk_drive_low, ps2_data_drive_low;
  logic [2:0] dbg_state;

  logic dev_clk;
  logic dev_data;

  int checks;
  int errors;
  int cyc;
  int done_cnt;

  logic [10:0] exp_q[$];

  ps2_host_transmitter #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TOUT)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .cmd_data           (cmd_data),
    .cmd_valid          (cmd_valid),
    .cmd_ready          (cmd_ready),
    .busy               (busy),
    .done               (done),
    .ack_error          (ack_error),
    .ps2_clk_in         (ps2_clk_in),
    .ps2_data_in        (ps2_data_in),
    .ps2_clk_drive_low  (ps2_clk_drive_low),
    .ps2_data_drive_low (ps2_data_drive_low),
    .dbg_state          (dbg_state)
  );

  // Open-drain bus: either side can pull a line low.
  assign ps2_clk_in  = dev_clk & ~ps2_clk_drive_low;
  assign ps2_data_in = dev_data & ~ps2_data_drive_low;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  initial done_cnt = 0;
  always @(negedge clock) if (done === 1'b1) done_cnt <= done_cnt + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic issue_and_inhibit(input logic [7:0] b, output int low_cnt, output int inh_cnt,
                                   output int both_cnt, output logic start_bit);
    low_cnt = 0; inh_cnt = 0; both_cnt = 0;
    @(negedge clock);
    cmd_data  = b;
    cmd_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (i == 0) begin
        cmd_valid = 1'b0;
        cmd_data  = 8'($urandom_range(0, 255));
      end
      if (ps2_clk_drive_low) begin
        low_cnt++;
        if (dbg_state == 3'd1) inh_cnt++;
        if (ps2_data_drive_low) both_cnt++;
      end else begin
        break;
      end
    end
    start_bit = ps2_data_in;
  endtask

  task automatic clock_edges(input int first, input int last, input logic ack_bit,
                             input int poke_edge, inout logic [10:0] frame, output int fall_cyc);
    fall_cyc = 0;
    for (int k = first; k <= last; k++) begin
      repeat (HALF) @(negedge clock);
      if (k == 11) dev_data = ack_bit;
      dev_clk  = 1'b0;
      fall_cyc = cyc;
      for (int j = 0; j < HALF; j++) begin
        @(negedge clock);
        if (k == poke_edge && j == 2) begin
          check("busy_cmd_ready", {31'd0, cmd_ready}, 32'd0);
          cmd_valid = 1'b1;
          cmd_data  = 8'h00;
        end else if (k == poke_edge && j == 3) begin
          cmd_valid = 1'b0;
        end
      end
      dev_clk = 1'b1;
      if (k <= 10) frame[k] = ps2_data_in;
      if (k == 11) dev_data = 1'b1;
    end
  endtask

  task automatic wait_done(input int max_cyc, output bit got, output logic err,
                           output int dcyc, output logic [1:0] drv);
    got = 0; err = 1'bx; dcyc = 0; drv = 2'bxx;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clock);
      if (done) begin
        got  = 1;
        err  = ack_error;
        dcyc = cyc;
        drv  = {ps2_clk_drive_low, ps2_data_drive_low};
        break;
      end
    end
  endtask

  task automatic do_transfer(input vec_t v, input int poke_edge);
    int low_cnt, inh_cnt, both_cnt, fc, dcyc, snap;
    logic start_bit, err;
    logic [10:0] frame, exp_frame;
    logic [1:0] drv;
    bit got;
    string tag;
    tag  = $sformatf("%02h", v.cmd);
    snap = done_cnt;
    exp_q.push_back({1'b1, v.exp_parity, v.cmd, 1'b0});
    issue_and_inhibit(v.cmd, low_cnt, inh_cnt, both_cnt, start_bit);
    check({"clk_low_total_", tag}, low_cnt, INH + 1);
    check({"clk_low_inhibit_", tag}, inh_cnt, INH);
    check({"rts_both_low_", tag}, both_cnt, 2);
    check({"start_bit_", tag}, {31'd0, start_bit}, 32'd0);
    frame    = '1;
    frame[0] = start_bit;
    clock_edges(1, 11, v.dev_ack, poke_edge, frame, fc);
    exp_frame = exp_q.pop_front();
    check({"frame_", tag}, {21'd0, frame}, {21'd0, exp_frame});
    check({"parity_", tag}, {31'd0, frame[9]}, {31'd0, v.exp_parity});
    wait_done(100, got, err, dcyc, drv);
    check({"done_seen_", tag}, {31'd0, got}, 32'd1);
    check({"ack_error_", tag}, {31'd0, err}, {31'd0, v.exp_err});
    @(negedge clock);
    check({"done_single_", tag}, {31'd0, done}, 32'd0);
    check({"ready_after_", tag}, {31'd0, cmd_ready}, 32'd1);
    check({"lines_free_", tag}, {30'd0, ps2_clk_drive_low, ps2_data_drive_low}, 32'd0);
    @(negedge clock);
    check({"done_count_", tag}, done_cnt - snap, 1);
  endtask

  vec_t vecs[4];

  initial begin
    int low_cnt, inh_cnt, both_cnt, fc, dcyc, snap, busy_cycles;
    logic start_bit, err;
    logic [10:0] frame;
    logic [1:0] drv;
    bit got;

    vecs[0] = '{8'hED, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{8'hF4, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 1'b1, 1'b1};
    vecs[3] = '{8'h00, 1'b0, 1'b1, 1'b0};

    checks = 0; errors = 0;
    reset = 1'b1; cmd_valid = 1'b0; cmd_data = 8'h00;
    dev_clk = 1'b1; dev_data = 1'b1;

    repeat (3) @(negedge clock);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_ack_error", {31'd0, ack_error}, 32'd0);
    check("rst_drives", {30'd0, ps2_clk_drive_low, ps2_data_drive_low}, 32'd0);
    check("rst_state", {29'd0, dbg_state}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Device clock activity while idle must not start anything.
    for (int i = 0; i < 4; i++) begin
      dev_clk = ~dev_clk;
      repeat (4) @(negedge clock);
    end
    check("idle_edges_state", {29'd0, dbg_state}, 32'd0);
    check("idle_edges_done", done_cnt, 0);

    for (int i = 0; i < 4; i++) do_transfer(vecs[i], 0);

    // Device stops after edge 4; the watchdog must close the transfer.
    snap = done_cnt;
    issue_and_inhibit(8'hF4, low_cnt, inh_cnt, both_cnt, start_bit);
    frame = '1;
    clock_edges(1, 4, 1'b1, 0, frame, fc);
    check("to_data_low_before", {31'd0, ps2_data_drive_low}, 32'd1);
    wait_done(TOUT + 50, got, err, dcyc, drv);
    check("to_done_seen", {31'd0, got}, 32'd1);
    check("to_latency", dcyc - fc, TOUT + SYNC_DELAY);
    check("to_ack_error", {31'd0, err}, 32'd1);
    check("to_drives_at_done", {30'd0, drv}, 32'd0);
    @(negedge clock);
    check("to_drives_after", {30'd0, ps2_clk_drive_low, ps2_data_drive_low}, 32'd0);
    check("to_ready_after", {31'd0, cmd_ready}, 32'd1);
    check("to_done_count", done_cnt - snap, 1);

    // Reset while bit 4 (a 0) of 0xED is being driven.
    snap = done_cnt;
    issue_and_inhibit(8'hED, low_cnt, inh_cnt, both_cnt, start_bit);
    frame = '1;
    clock_edges(1, 5, 1'b1, 0, frame, fc);
    repeat (3) @(negedge clock);
    check("rstmid_data_low_before", {31'd0, ps2_data_drive_low}, 32'd1);
    #3 reset = 1'b1;
    #1;
    check("rstmid_drives", {30'd0, ps2_clk_drive_low, ps2_data_drive_low}, 32'd0);
    check("rstmid_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rstmid_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    check("rstmid_no_done", done_cnt - snap, 0);
    do_transfer(vecs[1], 0);

    // A command offered mid-frame is dropped; the original frame goes out untouched.
    do_transfer(vecs[0], 5);
    busy_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (busy) busy_cycles++;
    end
    check("busy_no_second_frame", busy_cycles, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
